// File: rtl/mesi_snoop_bus_ctrl_pkg.sv
// Shared types for the MESI snooping bus controller: line states, bus ops, FSM states.
package mesi_snoop_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        MesiI = 2'b00,
        MesiS = 2'b01,
        MesiE = 2'b10,
        MesiM = 2'b11
    } mesi_state_t;

    typedef enum logic [1:0] {
        OpNone    = 2'b00,
        OpBusRd   = 2'b01,
        OpBusRdX  = 2'b10,
        OpBusUpgr = 2'b11
    } bus_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StBcast,
        StSnoop,
        StResp
    } fsm_state_t;

    // Only BusRd can be downgraded to a shared fill; ownership ops always end in M.
    function automatic mesi_state_t fill_for(bus_op_t op, logic any_hit);
        if (op == OpBusRd) begin
            return any_hit ? MesiS : MesiE;
        end
        return MesiM;
    endfunction

endpackage

// File: rtl/mesi_snoop_bus_ctrl_if.sv
// Cache-side request/snoop signals and bus-side outputs of the snooping bus controller.
interface mesi_snoop_bus_ctrl_if #(
    parameter int unsigned NUM_CACHES = 4,
    parameter int unsigned ADDR_W     = 32
);
    logic [NUM_CACHES-1:0]         req;
    logic [2*NUM_CACHES-1:0]       req_op;
    logic [ADDR_W*NUM_CACHES-1:0]  req_addr;
    logic [NUM_CACHES-1:0]         snoop_hit;
    logic [NUM_CACHES-1:0]         snoop_hitm;
    logic [NUM_CACHES-1:0]         gnt;
    logic                          bus_valid;
    logic [1:0]                    bus_op;
    logic [ADDR_W-1:0]             bus_addr;
    logic [$clog2(NUM_CACHES)-1:0] bus_src;
    logic                          done;
    logic [1:0]                    fill_state;
    logic                          flush_needed;

    modport master (
        input  req, req_op, req_addr, snoop_hit, snoop_hitm,
        output gnt, bus_valid, bus_op, bus_addr, bus_src, done, fill_state, flush_needed
    );

    modport slave (
        output req, req_op, req_addr, snoop_hit, snoop_hitm,
        input  gnt, bus_valid, bus_op, bus_addr, bus_src, done, fill_state, flush_needed
    );
endinterface

// File: rtl/mesi_snoop_bus_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after the pointer wins.
module mesi_snoop_bus_ctrl_rr_arbiter #(
    parameter int unsigned NUM_CACHES = 4,
    localparam int unsigned IDX_W     = $clog2(NUM_CACHES)
) (
    input  logic [NUM_CACHES-1:0] i_req,
    input  logic [IDX_W-1:0]      i_ptr,
    output logic [NUM_CACHES-1:0] o_gnt,
    output logic [IDX_W-1:0]      o_idx,
    output logic                  o_valid
);
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int unsigned off = 0; off < NUM_CACHES; off++) begin
            w_cand = IDX_W'((32'(i_ptr) + off) % NUM_CACHES);
            if (!o_valid && i_req[w_cand]) begin
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
                o_valid       = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mesi_snoop_bus_ctrl.sv
// Snooping coherence bus sequencer: grant -> broadcast -> snoop-collect -> response.
module mesi_snoop_bus_ctrl
    import mesi_snoop_bus_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CACHES = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned SNOOP_WAIT = 2
) (
    input logic                   clk,
    input logic                   reset,
    mesi_snoop_bus_ctrl_if.master bus
);
    localparam int unsigned IDX_W = $clog2(NUM_CACHES);
    localparam int unsigned CNT_W = $clog2(SNOOP_WAIT + 1);

    fsm_state_t            r_state, w_state_nxt;
    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      r_src;
    logic [NUM_CACHES-1:0] r_gnt;
    bus_op_t               r_op;
    logic [ADDR_W-1:0]     r_addr;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_hit;
    logic                  r_hitm;

    logic [NUM_CACHES-1:0] w_elig;
    logic [NUM_CACHES-1:0] w_arb_gnt;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_any;
    logic                  w_snoop_last;

    always_comb begin
        w_elig = '0;
        for (int unsigned i = 0; i < NUM_CACHES; i++) begin
            w_elig[i] = bus.req[i] && (bus.req_op[2*i +: 2] != 2'b00);
        end
    end

    mesi_snoop_bus_ctrl_rr_arbiter #(
        .NUM_CACHES (NUM_CACHES)
    ) u_arb (
        .i_req   (w_elig),
        .i_ptr   (r_ptr),
        .o_gnt   (w_arb_gnt),
        .o_idx   (w_idx),
        .o_valid (w_any)
    );

    assign w_snoop_last = (r_cnt == CNT_W'(SNOOP_WAIT - 1));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (w_any) w_state_nxt = StBcast;
            StBcast: w_state_nxt = StSnoop;
            StSnoop: if (w_snoop_last) w_state_nxt = StResp;
            StResp:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_ptr   <= '0;
            r_src   <= '0;
            r_gnt   <= '0;
            r_op    <= OpNone;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_hit   <= 1'b0;
            r_hitm  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            unique case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_src  <= w_idx;
                        r_gnt  <= w_arb_gnt;
                        r_op   <= bus_op_t'(bus.req_op[2*w_idx +: 2]);
                        r_addr <= bus.req_addr[ADDR_W*w_idx +: ADDR_W];
                        r_ptr  <= (w_idx == IDX_W'(NUM_CACHES - 1)) ? '0 : w_idx + 1'b1;
                    end
                end
                StBcast: r_cnt <= '0;
                StSnoop: begin
                    r_cnt  <= r_cnt + 1'b1;
                    // The requester may see its own line in the snoop; never count it.
                    r_hit  <= r_hit  | (|(bus.snoop_hit  & ~r_gnt));
                    r_hitm <= r_hitm | (|(bus.snoop_hitm & ~r_gnt));
                end
                StResp: begin
                    r_hit  <= 1'b0;
                    r_hitm <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.gnt          = (r_state != StIdle) ? r_gnt : '0;
        bus.bus_valid    = (r_state == StBcast);
        bus.done         = (r_state == StResp);
        bus.fill_state   = (r_state == StResp) ? fill_for(r_op, r_hit | r_hitm) : MesiI;
        bus.flush_needed = (r_state == StResp) && r_hitm;
        bus.bus_op       = r_op;
        bus.bus_addr     = r_addr;
        bus.bus_src      = r_src;
    end
endmodule

// File: tb/tb_mesi_snoop_bus_ctrl.sv
// Directed bench for mesi_snoop_bus_ctrl (4 caches, 2 snoop cycles); inputs change on negedge.
module tb_mesi_snoop_bus_ctrl;
    import mesi_snoop_bus_ctrl_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned SW = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    mesi_snoop_bus_ctrl_if #(.NUM_CACHES(N), .ADDR_W(AW)) bus_if ();

    mesi_snoop_bus_ctrl #(
        .NUM_CACHES (N),
        .ADDR_W     (AW),
        .SNOOP_WAIT (SW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_inputs();
        bus_if.req        = '0;
        bus_if.req_op     = '0;
        bus_if.req_addr   = '0;
        bus_if.snoop_hit  = '0;
        bus_if.snoop_hitm = '0;
    endtask

    task automatic set_req(input int idx, input logic [1:0] op, input logic [AW-1:0] addr);
        bus_if.req[idx]              = 1'b1;
        bus_if.req_op[2*idx +: 2]    = op;
        bus_if.req_addr[AW*idx +: AW] = addr;
    endtask

    // One full transaction from IDLE with snoop bits applied during both SNOOP cycles.
    task automatic run_txn(input int idx, input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic [N-1:0] hit, input logic [N-1:0] hitm,
                           output logic got_done, output logic [1:0] fill, output logic flush);
        set_req(idx, op, addr);
        tick();
        tick();
        bus_if.snoop_hit  = hit;
        bus_if.snoop_hitm = hitm;
        tick();
        tick();
        got_done = bus_if.done;
        fill     = bus_if.fill_state;
        flush    = bus_if.flush_needed;
        clear_inputs();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus_if.gnt, bus_if.bus_valid, bus_if.done, bus_if.fill_state,
             bus_if.flush_needed} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl: gnt=%b valid=%b done=%b fill=%b flush=%b, required all 0",
                     bus_if.gnt, bus_if.bus_valid, bus_if.done, bus_if.fill_state,
                     bus_if.flush_needed);
        end
        checks++;
        if ({bus_if.bus_op, bus_if.bus_addr, bus_if.bus_src} !== '0) begin
            failures++;
            $display("FAIL reset_latched: op=%b addr=%h src=%0d, required 0",
                     bus_if.bus_op, bus_if.bus_addr, bus_if.bus_src);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic_read();
        set_req(1, OpBusRd, 32'h100);
        tick();
        checks++;
        if (bus_if.bus_valid !== 1'b1 || bus_if.gnt !== 4'b0010) begin
            failures++;
            $display("FAIL basic_bcast: valid=%b gnt=%b, required 1 0010",
                     bus_if.bus_valid, bus_if.gnt);
        end
        checks++;
        if (bus_if.bus_src !== 2'd1 || bus_if.bus_addr !== 32'h100 || bus_if.bus_op !== 2'b01) begin
            failures++;
            $display("FAIL basic_latch: src=%0d addr=%h op=%b, required 1 00000100 01",
                     bus_if.bus_src, bus_if.bus_addr, bus_if.bus_op);
        end
        // Snoop bits during BCAST must be ignored.
        bus_if.snoop_hit  = '1;
        bus_if.snoop_hitm = '1;
        tick();
        bus_if.snoop_hit  = '0;
        bus_if.snoop_hitm = '0;
        checks++;
        if (bus_if.bus_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_valid_single: valid=%b, required 0", bus_if.bus_valid);
        end
        tick();
        checks++;
        if (bus_if.done !== 1'b0) begin
            failures++;
            $display("FAIL basic_early_done: done=%b, required 0", bus_if.done);
        end
        tick();
        checks++;
        if (bus_if.done !== 1'b1 || bus_if.fill_state !== 2'b10 || bus_if.flush_needed !== 1'b0) begin
            failures++;
            $display("FAIL basic_resp: done=%b fill=%b flush=%b, required 1 10 0",
                     bus_if.done, bus_if.fill_state, bus_if.flush_needed);
        end
        clear_inputs();
        tick();
        checks++;
        if (bus_if.done !== 1'b0 || bus_if.fill_state !== 2'b00 || bus_if.gnt !== 4'b0000) begin
            failures++;
            $display("FAIL basic_idle: done=%b fill=%b gnt=%b, required 0 00 0000",
                     bus_if.done, bus_if.fill_state, bus_if.gnt);
        end
    endtask

    task automatic test_snoop_shared();
        logic d;
        logic [1:0] f;
        logic fl;
        run_txn(0, OpBusRd, 32'h140, 4'b0100, 4'b0000, d, f, fl);
        checks++;
        if (d !== 1'b1 || f !== 2'b01 || fl !== 1'b0) begin
            failures++;
            $display("FAIL snoop_hit_s: done=%b fill=%b flush=%b, required 1 01 0", d, f, fl);
        end
        run_txn(0, OpBusRd, 32'h180, 4'b0000, 4'b1000, d, f, fl);
        checks++;
        if (d !== 1'b1 || f !== 2'b01 || fl !== 1'b1) begin
            failures++;
            $display("FAIL snoop_hitm_s: done=%b fill=%b flush=%b, required 1 01 1", d, f, fl);
        end
    endtask

    task automatic test_self_mask();
        logic d;
        logic [1:0] f;
        logic fl;
        run_txn(0, OpBusRdX, 32'h1C0, 4'b0001, 4'b0001, d, f, fl);
        checks++;
        if (d !== 1'b1 || f !== 2'b11 || fl !== 1'b0) begin
            failures++;
            $display("FAIL self_mask: done=%b fill=%b flush=%b, required 1 11 0", d, f, fl);
        end
    endtask

    task automatic test_mid_txn();
        int n_done;
        set_req(2, OpBusRdX, 32'h200);
        tick();
        tick();
        bus_if.req                = '0;
        bus_if.req_addr[AW*2 +: AW] = 32'hDEAD_0000;
        bus_if.req_op[4 +: 2]     = 2'b01;
        tick();
        checks++;
        if (bus_if.bus_addr !== 32'h200 || bus_if.bus_src !== 2'd2 || bus_if.bus_op !== 2'b10
            || bus_if.gnt !== 4'b0100) begin
            failures++;
            $display("FAIL mid_stable: addr=%h src=%0d op=%b gnt=%b, required 00000200 2 10 0100",
                     bus_if.bus_addr, bus_if.bus_src, bus_if.bus_op, bus_if.gnt);
        end
        tick();
        checks++;
        if (bus_if.done !== 1'b1 || bus_if.fill_state !== 2'b11) begin
            failures++;
            $display("FAIL mid_done: done=%b fill=%b, required 1 11",
                     bus_if.done, bus_if.fill_state);
        end
        clear_inputs();
        tick();
        // Abort by reset while snooping.
        set_req(2, OpBusRd, 32'h300);
        tick();
        tick();
        reset = 1'b1;
        clear_inputs();
        tick();
        checks++;
        if ({bus_if.gnt, bus_if.bus_valid, bus_if.done, bus_if.fill_state, bus_if.flush_needed,
             bus_if.bus_op, bus_if.bus_addr, bus_if.bus_src} !== '0) begin
            failures++;
            $display("FAIL abort_zero: gnt=%b valid=%b done=%b addr=%h src=%0d, required all 0",
                     bus_if.gnt, bus_if.bus_valid, bus_if.done, bus_if.bus_addr, bus_if.bus_src);
        end
        reset  = 1'b0;
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus_if.done === 1'b1) n_done++;
        end
        checks++;
        if (n_done != 0) begin
            failures++;
            $display("FAIL abort_no_done: done_pulses=%0d, required 0", n_done);
        end
        set_req(0, OpBusRd, 32'h400);
        set_req(3, OpBusRd, 32'h700);
        tick();
        checks++;
        if (bus_if.bus_valid !== 1'b1 || bus_if.bus_src !== 2'd0) begin
            failures++;
            $display("FAIL abort_ptr: valid=%b src=%0d, required 1 0",
                     bus_if.bus_valid, bus_if.bus_src);
        end
        tick();
        tick();
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        int exp_src [5] = '{0, 1, 2, 3, 0};
        int n_valid = 0;
        int n_done  = 0;
        int last    = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, OpBusRd, AW'(32'h1000 + 32'(i) * 32'h40));
        for (int c = 0; c < 40 && n_done < 5; c++) begin
            tick();
            if (bus_if.bus_valid === 1'b1) begin
                checks++;
                if (n_valid >= 5 || 32'(bus_if.bus_src) != 32'(exp_src[n_valid])) begin
                    failures++;
                    $display("FAIL rr_order[%0d]: src=%0d, required %0d", n_valid,
                             bus_if.bus_src, exp_src[n_valid % 5]);
                end
                n_valid++;
            end
            if (bus_if.done === 1'b1) begin
                if (n_done > 0) begin
                    checks++;
                    if (cyc - last != 5) begin
                        failures++;
                        $display("FAIL rr_spacing[%0d]: gap=%0d, required 5", n_done, cyc - last);
                    end
                end
                last = cyc;
                n_done++;
                if (n_done == 5) clear_inputs();
            end
        end
        checks++;
        if (n_done != 5 || n_valid != n_done) begin
            failures++;
            $display("FAIL rr_counts: done=%0d valid=%0d, required 5 5", n_done, n_valid);
        end
        tick();
    endtask

    task automatic test_op_none_upgr();
        logic d;
        logic [1:0] f;
        logic fl;
        int seen = 0;
        set_req(2, OpNone, 32'h240);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus_if.gnt !== 4'b0000 || bus_if.bus_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL op_none_grant: active_cycles=%0d, required 0", seen);
        end
        run_txn(2, OpBusUpgr, 32'h2C0, 4'b1011, 4'b0000, d, f, fl);
        checks++;
        if (d !== 1'b1 || f !== 2'b11 || fl !== 1'b0) begin
            failures++;
            $display("FAIL upgr_fill: done=%b fill=%b flush=%b, required 1 11 0", d, f, fl);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_basic_read();
        test_snoop_shared();
        test_self_mask();
        test_mid_txn();
        test_back_to_back();
        test_op_none_upgr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
